// File: rtl/dither_loop_filter.sv
// rtl/dither_loop_filter.sv - shift-gain PI loop filter producing a saturated step and a wrapping phase ramp
// Optional debug taps o_err/o_integ are enabled with DITHER_LOOP_DBG_EN.
module dither_loop_filter #(
  parameter int             DW        = 32,
  parameter logic [DW-1:0]  STEP_LIM  = 32'h3FFF_FFFF,
  parameter logic [DW-1:0]  INTEG_LIM = 32'h1FFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_data_vld,
  input  logic signed [DW-1:0] i_data,
  input  logic signed [DW-1:0] i_err_offset,
  input  logic [4:0]           i_kp_sft,
  input  logic [4:0]           i_ki_sft,
  input  logic                 i_loop_en,
  output logic signed [DW-1:0] o_step,
  output logic                 o_step_vld,
  output logic signed [DW-1:0] o_ramp,
  output logic                 o_sat,
  output logic                 o_ovr,
  output logic [2:0]           o_cstate
`ifdef DITHER_LOOP_DBG_EN
  ,
  output logic signed [DW-1:0] o_err,
  output logic signed [DW-1:0] o_integ
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SUB  = 3'd1,
    S_GAIN = 3'd2,
    S_ACC  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  localparam logic signed [DW:0] DW_MAX   = $signed({2'b00, {(DW-1){1'b1}}});
  localparam logic signed [DW:0] DW_MIN   = $signed({2'b11, {(DW-1){1'b0}}});
  localparam logic signed [DW:0] STEP_HI  = $signed({1'b0, STEP_LIM});
  localparam logic signed [DW:0] STEP_LO  = -STEP_HI;
  localparam logic signed [DW:0] INTEG_HI = $signed({1'b0, INTEG_LIM});
  localparam logic signed [DW:0] INTEG_LO = -INTEG_HI;

  function automatic logic signed [DW-1:0] clamp(input logic signed [DW:0] v,
                                                 input logic signed [DW:0] hi,
                                                 input logic signed [DW:0] lo);
    if (v > hi)      return hi[DW-1:0];
    else if (v < lo) return lo[DW-1:0];
    else             return v[DW-1:0];
  endfunction

  state_t state, state_nxt;

  logic signed [DW-1:0] data_r, off_r, err_r, p_r, inc_r, integ_r;
  logic [4:0]           kp_r, ki_r;
  logic                 en_r;

  logic signed [DW:0]   diff, integ_sum, step_sum;
  logic signed [DW-1:0] err_sat, integ_nxt, step_nxt;
  logic                 integ_hit, step_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_data_vld) state_nxt = S_SUB;
      S_SUB:   state_nxt = S_GAIN;
      S_GAIN:  state_nxt = S_ACC;
      S_ACC:   state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // All sums are formed one bit wider so the clamps see the true result.
  always_comb begin
    diff      = {data_r[DW-1], data_r} - {off_r[DW-1], off_r};
    err_sat   = clamp(diff, DW_MAX, DW_MIN);
    integ_sum = {integ_r[DW-1], integ_r} + {inc_r[DW-1], inc_r};
    integ_nxt = clamp(integ_sum, INTEG_HI, INTEG_LO);
    integ_hit = (integ_sum > INTEG_HI) || (integ_sum < INTEG_LO);
    step_sum  = {p_r[DW-1], p_r} + {integ_nxt[DW-1], integ_nxt};
    step_nxt  = clamp(step_sum, STEP_HI, STEP_LO);
    step_hit  = (step_sum > STEP_HI) || (step_sum < STEP_LO);
  end

  // Outputs are written on the ACC edge so they are valid together with the strobe during OUT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_r     <= '0;
      off_r      <= '0;
      kp_r       <= '0;
      ki_r       <= '0;
      en_r       <= 1'b0;
      err_r      <= '0;
      p_r        <= '0;
      inc_r      <= '0;
      integ_r    <= '0;
      o_step     <= '0;
      o_ramp     <= '0;
      o_sat      <= 1'b0;
      o_step_vld <= 1'b0;
      o_ovr      <= 1'b0;
    end else begin
      o_step_vld <= 1'b0;
      if (i_data_vld && (state != S_IDLE)) o_ovr <= 1'b1;
      case (state)
        S_IDLE: begin
          if (i_data_vld) begin
            data_r <= i_data;
            off_r  <= i_err_offset;
            kp_r   <= i_kp_sft;
            ki_r   <= i_ki_sft;
            en_r   <= i_loop_en;
          end
        end
        S_SUB: err_r <= err_sat;
        S_GAIN: begin
          p_r   <= err_r >>> kp_r;
          inc_r <= err_r >>> ki_r;
        end
        S_ACC: begin
          o_step_vld <= 1'b1;
          if (en_r) begin
            integ_r <= integ_nxt;
            o_step  <= step_nxt;
            o_ramp  <= o_ramp + step_nxt;
            o_sat   <= integ_hit | step_hit;
          end else begin
            integ_r <= '0;
            o_step  <= '0;
            o_sat   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cstate = state;

`ifdef DITHER_LOOP_DBG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err   <= '0;
      o_integ <= '0;
    end else if (state == S_ACC) begin
      o_err   <= err_r;
      o_integ <= en_r ? integ_nxt : '0;
    end
  end
`endif

endmodule

// File: tb/tb_dither_loop_filter.sv
// tb/tb_dither_loop_filter.sv - directed and randomized checks of dither_loop_filter against an arithmetic model
module tb_dither_loop_filter;

  localparam longint SL = 64'h3FFF_FFFF;
  localparam longint IL = 64'h1FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] off = '0;
  logic [4:0]  kp = '0;
  logic [4:0]  ki = '0;
  logic        en = 1'b0;
  logic [31:0] o_step, o_ramp;
  logic        o_step_vld, o_sat, o_ovr;
  logic [2:0]  o_cstate;
`ifdef DITHER_LOOP_DBG_EN
  logic [31:0] o_err, o_integ;
`endif

  int tests = 0;
  int fails = 0;

  longint m_integ = 0;
  int     m_ramp = 0;
  int     e_step = 0;
  bit     e_sat = 1'b0;

  always #5 clk = ~clk;

  dither_loop_filter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data_vld   (vld),
    .i_data       (data),
    .i_err_offset (off),
    .i_kp_sft     (kp),
    .i_ki_sft     (ki),
    .i_loop_en    (en),
    .o_step       (o_step),
    .o_step_vld   (o_step_vld),
    .o_ramp       (o_ramp),
    .o_sat        (o_sat),
    .o_ovr        (o_ovr),
    .o_cstate     (o_cstate)
`ifdef DITHER_LOOP_DBG_EN
    ,
    .o_err        (o_err),
    .o_integ      (o_integ)
`endif
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clip(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: one PI update computed directly from the rules in 64-bit arithmetic.
  task automatic model(input int d, input int o, input int kps, input int kis, input bit le);
    longint err, p, inc, ti, ts;
    err = clip(longint'(d) - longint'(o), -64'sd2147483648, 64'sd2147483647);
    p   = err >>> kps;
    inc = err >>> kis;
    if (le) begin
      ti      = m_integ + inc;
      m_integ = clip(ti, -IL, IL);
      ts      = p + m_integ;
      e_step  = int'(clip(ts, -SL, SL));
      e_sat   = (ti > IL) || (ti < -IL) || (ts > SL) || (ts < -SL);
      m_ramp  = m_ramp + e_step;
    end else begin
      m_integ = 0;
      e_step  = 0;
      e_sat   = 1'b0;
    end
  endtask

  // One strobe; optional extra strobe at cycle 'extra' (2..4) while the FSM is busy.
  task automatic send(input int d, input int o, input int kps, input int kis, input bit le,
                      input int extra);
    int   lat, pulses;
    logic [31:0] cs, cr;
    logic        csat;
    lat = 0; pulses = 0; cs = '0; cr = '0; csat = 1'b0;
    @(negedge clk);
    vld = 1'b1; data = d; off = o; kp = kps[4:0]; ki = kis[4:0]; en = le;
    model(d, o, kps, kis, le);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == extra) begin
        vld = 1'b1; data = $urandom; off = $urandom; kp = 5'd0; en = 1'b1;
      end else begin
        vld = 1'b0;
      end
      if (k <= 4) chk("cstate", longint'(o_cstate), longint'(k));
      if (o_step_vld === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = k; cs = o_step; cr = o_ramp; csat = o_sat;
        end
      end
    end
    chk("latency", longint'(lat), 4);
    chk("pulses", longint'(pulses), 1);
    chk("step", longint'($signed(cs)), longint'(e_step));
    chk("ramp", longint'($signed(cr)), longint'(m_ramp));
    chk("sat", longint'(csat), longint'(e_sat));
    chk("step_hold", longint'($signed(o_step)), longint'(e_step));
  endtask

  initial begin
    // Reset with strobes toggling
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vld = ~vld; data = 32'd1234;
    end
    chk("rst_step", longint'(o_step), 0);
    chk("rst_ramp", longint'(o_ramp), 0);
    chk("rst_vld", longint'(o_step_vld), 0);
    chk("rst_sat", longint'(o_sat), 0);
    chk("rst_ovr", longint'(o_ovr), 0);
    chk("rst_cstate", longint'(o_cstate), 0);
    @(negedge clk);
    vld = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ovr", longint'(o_ovr), 0);

    // Basic PI
    send(1000, 0, 1, 2, 1'b1, 0);
    chk("pi1_step", longint'($signed(o_step)), 750);
    send(1000, 0, 1, 2, 1'b1, 0);
    chk("pi2_step", longint'($signed(o_step)), 1000);
    chk("pi2_ramp", longint'($signed(o_ramp)), 1750);

    // Open loop: step 0, ramp held, integrator cleared
    send(12345, 0, 0, 0, 1'b0, 0);
    chk("ol_ramp", longint'($signed(o_ramp)), 1750);

    // Offset with negative error, ki shift of 31
    send(-3100, -100, 0, 31, 1'b1, 0);

    // Error saturation and integrator pinning
    for (int i = 0; i < 3; i++) send(int'(32'h7FFF_FFFF), int'(32'h8000_0000), 0, 0, 1'b1, 0);
    chk("sat_flag", longint'(o_sat), 1);
    send(0, 0, 31, 31, 1'b1, 0);
    chk("integ_pinned", longint'($signed(o_step)), IL);

    // Ramp wrap with an unclamped step of exactly STEP_LIM
    send(0, 0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 6; i++) send(int'(32'h3FFF_FFFF), 0, 0, 31, 1'b1, 0);

    // Busy overrun, including a strobe during OUT
    chk("ovr_clear", longint'(o_ovr), 0);
    send(500, 0, 0, 3, 1'b1, 2);
    chk("ovr_set", longint'(o_ovr), 1);
    send(-700, 0, 1, 4, 1'b1, 4);
    send(42, 0, 0, 5, 1'b1, 0);
    chk("ovr_sticky", longint'(o_ovr), 1);

    // Open loop clears integrator
    send(9999, 0, 0, 0, 1'b0, 0);
    send(0, 0, 31, 31, 1'b1, 0);
    chk("integ_cleared", longint'($signed(o_step)), 0);

    // Reset during a calculation
    @(negedge clk);
    vld = 1'b1; data = 32'd5000; off = '0; kp = 5'd0; en = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cstate", longint'(o_cstate), 0);
    chk("midrst_ovr", longint'(o_ovr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_integ = 0; m_ramp = 0;
    begin
      int p;
      p = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (o_step_vld === 1'b1) p++;
      end
      chk("midrst_no_vld", longint'(p), 0);
    end
    chk("midrst_ramp", longint'(o_ramp), 0);
    send(100, 0, 0, 0, 1'b1, 0);

    // Randomized updates
    for (int n = 0; n < 30; n++) begin
      int d, o;
      case ($urandom_range(0, 2))
        0: begin d = int'($urandom); o = int'($urandom); end
        1: begin d = int'($urandom_range(0, 200000)) - 100000; o = int'($urandom_range(0, 2000)) - 1000; end
        default: begin d = $urandom_range(0, 1) ? int'(32'h7FFF_FFF0) : int'(32'h8000_0010); o = int'($urandom_range(0, 64)) - 32; end
      endcase
      send(d, o, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           ($urandom_range(0, 3) != 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
